mk_top: RTL and testbench
=========================

// Module: mk_top
// PURPOSE
// - Minimal multicycle RV32I processor core; top of the SoC compute path.
// - Issues one memory request at a time on a get-style request port.
// - Consumes exactly one response per request on a put-style response port.
// - The SoC routes requests to block RAM (1-cycle response) or to MMIO
//   devices (LED, SPI, GPIO; same-cycle response).
// PARAMETERS
// - RESET_PC  32'h0000_0000  address of first instruction fetch after reset
// PORTS
// - CLK                  in   1   single clock; all state on rising edge
// - RST                  in   1   asynchronous, active-high reset
// - obtain_rq_get        out  65  request {addr[64:33], iswrite[32], wdata[31:0]}
// - RDY_obtain_rq_get    out  1   request valid
// - EN_obtain_rq_get     in   1   request taken this cycle (asserted only while RDY)
// - send_rs_put          in   32  response data (read data; don't-care for writes)
// - EN_send_rs_put       in   1   response valid
// - RDY_send_rs_put      out  1   core can take a response (high while one is outstanding)
// BEHAVIOUR
// - Reset: pc=RESET_PC; x1..x31=0; state=FETCH.
//   Outputs during reset: RDY_obtain_rq_get=0, RDY_send_rs_put=0, obtain_rq_get=0.
// - x0 reads as 0; writes to x0 are dropped.
// - Request handshake:
//   - RDY rises with a stable payload; payload and RDY hold until the EN cycle.
//   - RDY drops the cycle after EN.
//   - At most one request outstanding.
// - Response handshake:
//   - A response may arrive in the same cycle as EN_obtain_rq_get (combinational MMIO path) or any later cycle.
//   - RDY_send_rs_put=1 from the EN_obtain_rq_get cycle until the response is taken.
//   - Core must never drop a response.
//   - Writes also receive a response; its data is ignored.
// - States:
//   - FETCH: request {pc, 0, x}.
//   - IWAIT: await instruction word.
//   - EXEC: decode and execute in 1 cycle.
//   - MREQ / MWAIT: data access.
//   - RMW_RD / RMW_WR: sub-word store.
//   - HALT: terminal.
// - ALU, LUI, AUIPC, JAL, JALR, branches: EXEC -> FETCH; pc updated in EXEC.
//   - JALR target clears bit 0.
//   - Arithmetic mod 2^32; shift amount = low 5 bits.
//   - Misaligned targets are permitted; no exception.
// - Memory interface is word-only; addresses are byte addresses, unaligned allowed.
//   A read returns 4 bytes starting at addr (little-endian).
// - LW/LH/LHU/LB/LBU: one read at rs1+imm.
//   - LW takes the full word.
//   - LH/LHU take [15:0]; LB/LBU take [7:0], sign- or zero-extended.
// - SW: one write {addr, 1, rs2}.
// - SH/SB: read-modify-write at addr, two transactions:
//   - read old word;
//   - write {old[31:16], rs2[15:0]} (SH) or {old[31:8], rs2[7:0]} (SB).
// - FENCE, ECALL, EBREAK, CSR*: executed as NOP (pc+4).
// - Illegal or unsupported opcode: enter HALT.
//   HALT issues no requests and stays there until reset.
// - Reset mid-transaction:
//   - Abandon outstanding request or response.
//   - A response arriving during or after reset, before the new FETCH, is discarded.
// CONFIGURATION
// - MK_TOP_MUL_EN defined: MUL, MULH, MULHSU, MULHU supported.
//   - Implemented as an iterative 32-cycle shift-add in a MUL state; then FETCH.
// - MK_TOP_MUL_EN undefined: any OP-funct7=0000001 instruction is illegal -> HALT.
// TESTING
// - Reset, RAM at 0 holds ADDI x1,x0,5:
//   - first request {0,0,x}; after execution x1=5;
//   - next request addr=4.
// - LUI x2,0x10012; SW x1,12(x2) with x1=0x00800000:
//   - write request {0x1001200c, 1, 0x00800000};
//   - same-cycle response accepted; no stall.
// - SB of x3=0xAB to addr 0x101, old word 0x11223344:
//   - read {0x101,0,x} then write {0x101,1,0x112233AB}.
// - LB from a word reading 0x000000F0 -> rd=0xFFFFFFF0; LBU -> 0x000000F0.
// - BNE loop x1 count 3->0: exactly 3 taken branches; pc then pc+4; RDY hold under EN=0 for 5 cycles.
// - Opcode 0x0000007F -> HALT, RDY_obtain_rq_get stays 0.
//   With MK_TOP_MUL_EN: MUL 7*-3 = 0xFFFFFFEB.

Source files
------------

// File: rtl/mk_top.sv
// Multicycle RV32I core with a single-outstanding get/put memory port.
// Define MK_TOP_MUL_EN to add MUL/MULH/MULHSU/MULHU via an iterative shift-add unit.
module mk_top #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [64:0] obtain_rq_get,
    output logic        RDY_obtain_rq_get,
    input  logic        EN_obtain_rq_get,
    input  logic [31:0] send_rs_put,
    input  logic        EN_send_rs_put,
    output logic        RDY_send_rs_put
);

    typedef enum logic [3:0] {
        StFetch, StIwait, StExec, StMreq, StMwait, StRmwRd, StRmwWr, StHalt, StMul
    } state_e;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:8] old_q, old_d;
    logic        rmw_q, rmw_d;
    logic        live_q;
    logic [31:0] rf_q [32];

    logic        rf_we;
    logic [31:0] rf_wd;
    logic        data_done;
    logic        illegal;

`ifdef MK_TOP_MUL_EN
    logic [63:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic [63:0] mul_acc_q, mul_acc_d;
    logic [4:0]  mul_cnt_q, mul_cnt_d;
    logic        mul_neg_q, mul_neg_d;
    logic        mul_hi_q, mul_hi_d;
    logic [63:0] mul_acc_nx, mul_prod;
    logic        mul_a_neg, mul_b_neg;
`endif

    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] rs1_v, rs2_v;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] maddr, merged;
    logic        is_store, rmw_phase;
    logic        eq, lt, ltu, taken;
    logic        rq_rdy, rq_fire, rs_rdy, rs_fire;
    logic [64:0] rq_payload;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign f7     = ir_q[31:25];

    // rf_q[0] is reset to zero and never written, so x0 reads as 0.
    assign rs1_v = rf_q[rs1];
    assign rs2_v = rf_q[rs2];

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'h000};
    assign imm_j = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    assign is_store = (opcode == OpStore);
    assign maddr    = rs1_v + (is_store ? imm_s : imm_i);
    assign merged   = (f3 == 3'b001) ? {old_q[31:16], rs2_v[15:0]} : {old_q[31:8], rs2_v[7:0]};

    assign eq  = (rs1_v == rs2_v);
    assign lt  = ($signed(rs1_v) < $signed(rs2_v));
    assign ltu = (rs1_v < rs2_v);

`ifdef MK_TOP_MUL_EN
    assign mul_a_neg = ((f3 == 3'b001) || (f3 == 3'b010)) && rs1_v[31];
    assign mul_b_neg = (f3 == 3'b001) && rs2_v[31];
`endif

    function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            3'b000:  r = alt ? a - b : a + b;
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'b0, $signed(a) < $signed(b)};
            3'b011:  r = {31'b0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [31:0] w);
        logic [31:0] r;
        case (op)
            3'b000:  r = {{24{w[7]}}, w[7:0]};
            3'b001:  r = {{16{w[15]}}, w[15:0]};
            3'b100:  r = {24'h0, w[7:0]};
            3'b101:  r = {16'h0, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Handshake: live_q holds requests off until the first clock after reset.
    assign rq_rdy  = live_q && (state_q inside {StFetch, StMreq, StRmwRd, StRmwWr});
    assign rq_fire = rq_rdy && EN_obtain_rq_get;
    assign rs_rdy  = (state_q inside {StIwait, StMwait}) || rq_fire;
    assign rs_fire = rs_rdy && EN_send_rs_put;
    assign rmw_phase = rmw_q || (state_q == StRmwRd);

    always_comb begin
        rq_payload = '0;
        case (state_q)
            StFetch: rq_payload = {pc_q, 1'b0, 32'h0};
            StMreq:  rq_payload = is_store ? {maddr, 1'b1, rs2_v} : {maddr, 1'b0, 32'h0};
            StRmwRd: rq_payload = {maddr, 1'b0, 32'h0};
            StRmwWr: rq_payload = {maddr, 1'b1, merged};
            default: rq_payload = '0;
        endcase
    end

    assign RDY_obtain_rq_get = rq_rdy;
    assign obtain_rq_get     = rq_rdy ? rq_payload : 65'h0;
    assign RDY_send_rs_put   = rs_rdy;

    always_comb begin
        case (f3)
            3'b000:  taken = eq;
            3'b001:  taken = !eq;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            default: taken = !ltu;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        old_d     = old_q;
        rmw_d     = rmw_q;
        rf_we     = 1'b0;
        rf_wd     = 32'h0;
        data_done = 1'b0;
        illegal   = 1'b0;
`ifdef MK_TOP_MUL_EN
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        mul_acc_d  = mul_acc_q;
        mul_cnt_d  = mul_cnt_q;
        mul_neg_d  = mul_neg_q;
        mul_hi_d   = mul_hi_q;
        mul_acc_nx = mul_acc_q + (mul_b_q[0] ? mul_a_q : 64'h0);
        mul_prod   = mul_neg_q ? -mul_acc_nx : mul_acc_nx;
`endif
        unique case (state_q)
            StFetch, StIwait: begin
                if ((state_q == StFetch && rq_fire) || state_q == StIwait) begin
                    if (rs_fire) begin
                        ir_d    = send_rs_put;
                        state_d = StExec;
                    end else begin
                        state_d = StIwait;
                    end
                end
            end
            StExec: begin
                pc_d    = pc_q + 32'd4;
                state_d = StFetch;
                case (opcode)
                    OpLui: begin
                        rf_we = 1'b1;
                        rf_wd = imm_u;
                    end
                    OpAuipc: begin
                        rf_we = 1'b1;
                        rf_wd = pc_q + imm_u;
                    end
                    OpJal: begin
                        rf_we = 1'b1;
                        rf_wd = pc_q + 32'd4;
                        pc_d  = pc_q + imm_j;
                    end
                    OpJalr: begin
                        illegal = (f3 != 3'b000);
                        rf_we   = 1'b1;
                        rf_wd   = pc_q + 32'd4;
                        pc_d    = (rs1_v + imm_i) & ~32'd1;
                    end
                    OpBranch: begin
                        illegal = (f3 == 3'b010) || (f3 == 3'b011);
                        if (taken) pc_d = pc_q + imm_b;
                    end
                    OpLoad: begin
                        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                        state_d = StMreq;
                    end
                    OpStore: begin
                        illegal = (f3 > 3'b010);
                        state_d = (f3 == 3'b010) ? StMreq : StRmwRd;
                    end
                    OpImm: begin
                        illegal = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                                  ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
                        rf_we   = 1'b1;
                        rf_wd   = alu(f3, (f3 == 3'b101) && ir_q[30], rs1_v, imm_i);
                    end
                    OpReg: begin
                        if (f7 == 7'b0000000) begin
                            rf_we = 1'b1;
                            rf_wd = alu(f3, 1'b0, rs1_v, rs2_v);
                        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
                            rf_we = 1'b1;
                            rf_wd = alu(f3, 1'b1, rs1_v, rs2_v);
`ifdef MK_TOP_MUL_EN
                        end else if (f7 == 7'b0000001 && !f3[2]) begin
                            // Multiply unsigned magnitudes, fix the sign at the end.
                            mul_a_d   = {32'h0, mul_a_neg ? -rs1_v : rs1_v};
                            mul_b_d   = mul_b_neg ? -rs2_v : rs2_v;
                            mul_acc_d = 64'h0;
                            mul_cnt_d = 5'd0;
                            mul_neg_d = mul_a_neg ^ mul_b_neg;
                            mul_hi_d  = (f3 != 3'b000);
                            state_d   = StMul;
`endif
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    OpFence, OpSystem: ;
                    default: illegal = 1'b1;
                endcase
            end
            StMreq, StRmwRd, StRmwWr: begin
                if (rq_fire) begin
                    if (state_q == StRmwRd) rmw_d = 1'b1;
                    if (rs_fire) data_done = 1'b1;
                    else state_d = StMwait;
                end
            end
            StMwait: begin
                if (rs_fire) data_done = 1'b1;
            end
            StMul: begin
`ifdef MK_TOP_MUL_EN
                mul_acc_d = mul_acc_nx;
                mul_a_d   = mul_a_q << 1;
                mul_b_d   = mul_b_q >> 1;
                mul_cnt_d = mul_cnt_q + 5'd1;
                if (mul_cnt_q == 5'd31) begin
                    rf_we   = 1'b1;
                    rf_wd   = mul_hi_q ? mul_prod[63:32] : mul_prod[31:0];
                    state_d = StFetch;
                end
`else
                state_d = StHalt;
`endif
            end
            StHalt: ;
            default: state_d = StHalt;
        endcase

        if (data_done) begin
            if (opcode == OpLoad) begin
                rf_we   = 1'b1;
                rf_wd   = load_ext(f3, send_rs_put);
                state_d = StFetch;
            end else if (rmw_phase) begin
                old_d   = send_rs_put[31:8];
                rmw_d   = 1'b0;
                state_d = StRmwWr;
            end else begin
                state_d = StFetch;
            end
        end

        if (illegal) begin
            state_d = StHalt;
            pc_d    = pc_q;
            rf_we   = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0;
            old_q   <= 24'h0;
            rmw_q   <= 1'b0;
            live_q  <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
`ifdef MK_TOP_MUL_EN
            mul_a_q   <= 64'h0;
            mul_b_q   <= 32'h0;
            mul_acc_q <= 64'h0;
            mul_cnt_q <= 5'd0;
            mul_neg_q <= 1'b0;
            mul_hi_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            old_q   <= old_d;
            rmw_q   <= rmw_d;
            live_q  <= 1'b1;
            if (rf_we && rd != 5'd0) rf_q[rd] <= rf_wd;
`ifdef MK_TOP_MUL_EN
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            mul_acc_q <= mul_acc_d;
            mul_cnt_q <= mul_cnt_d;
            mul_neg_q <= mul_neg_d;
            mul_hi_q  <= mul_hi_d;
`endif
        end
    end

endmodule

// File: tb/tb_mk_top.sv
// Directed bench for mk_top: a byte-array memory answers requests, a queue of
// expected requests is checked as the core issues them.
module tb_mk_top;

    logic        CLK = 1'b0;
    logic        RST;
    logic [64:0] obtain_rq_get;
    logic        RDY_obtain_rq_get;
    logic        EN_obtain_rq_get;
    logic [31:0] send_rs_put;
    logic        EN_send_rs_put;
    logic        RDY_send_rs_put;

    int total = 0;
    int bad   = 0;
    int nreq  = 0;

    logic [64:0] exp_q[$];
    logic [7:0]  mem [1024];

    always #5 CLK = ~CLK;

    mk_top dut (
        .CLK              (CLK),
        .RST              (RST),
        .obtain_rq_get    (obtain_rq_get),
        .RDY_obtain_rq_get(RDY_obtain_rq_get),
        .EN_obtain_rq_get (EN_obtain_rq_get),
        .send_rs_put      (send_rs_put),
        .EN_send_rs_put   (EN_send_rs_put),
        .RDY_send_rs_put  (RDY_send_rs_put)
    );

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] rd32(input logic [31:0] a);
        int idx;
        idx = int'(a);
        if (a < 32'd1021) return {mem[idx+3], mem[idx+2], mem[idx+1], mem[idx]};
        return 32'h0;
    endfunction

    task automatic put32(input logic [31:0] a, input logic [31:0] w);
        int idx;
        idx = int'(a);
        if (a < 32'd1021) begin
            mem[idx]   = w[7:0];
            mem[idx+1] = w[15:8];
            mem[idx+2] = w[23:16];
            mem[idx+3] = w[31:24];
        end
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1,
                                          input int f3);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                          input int f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input int imm, input int rd, input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[19:0], 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
    endfunction

    task automatic exp_rd(input logic [31:0] a);
        exp_q.push_back({a, 1'b0, 32'h0});
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, 1'b1, d});
    endtask

    // Called at a negedge; returns at a negedge (or #1 after posedge when drop=1).
    task automatic serve(input bit same, input int hold, input bit drop);
        logic [64:0] got, want, masked;
        logic [31:0] rsp;
        int n;
        n = 0;
        while (RDY_obtain_rq_get !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (RDY_obtain_rq_get !== 1'b1) begin
            chk($sformatf("req%0d_timeout", nreq), {64'h0, RDY_obtain_rq_get}, 65'h1);
            nreq++;
            return;
        end
        want   = (exp_q.size() != 0) ? exp_q.pop_front() : {65{1'b1}};
        got    = obtain_rq_get;
        masked = got[32] ? got : {got[64:32], 32'h0};
        chk($sformatf("req%0d", nreq), masked, want);
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            chk($sformatf("req%0d_hold_rdy", nreq), {64'h0, RDY_obtain_rq_get}, 65'h1);
            chk($sformatf("req%0d_hold_data", nreq), obtain_rq_get, got);
        end
        if (got[32]) begin
            put32(got[64:33], got[31:0]);
            rsp = 32'hDEAD_BEEF;
        end else begin
            rsp = rd32(got[64:33]);
        end
        EN_obtain_rq_get = 1'b1;
        if (same) begin
            EN_send_rs_put = 1'b1;
            send_rs_put    = rsp;
            #1;
            chk($sformatf("req%0d_rs_rdy_same", nreq), {64'h0, RDY_send_rs_put}, 65'h1);
        end
        @(posedge CLK);
        #1;
        EN_obtain_rq_get = 1'b0;
        EN_send_rs_put   = 1'b0;
        if (!same) begin
            chk($sformatf("req%0d_rq_drop", nreq), {64'h0, RDY_obtain_rq_get}, 65'h0);
            chk($sformatf("req%0d_rs_rdy", nreq), {64'h0, RDY_send_rs_put}, 65'h1);
            if (drop) begin
                nreq++;
                return;
            end
            EN_send_rs_put = 1'b1;
            send_rs_put    = rsp;
            @(posedge CLK);
            #1;
            EN_send_rs_put = 1'b0;
        end
        nreq++;
        @(negedge CLK);
    endtask

    task automatic check_quiet(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            seen = seen | RDY_obtain_rq_get;
        end
        chk(tag, {64'h0, seen}, 65'h0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        EN_obtain_rq_get = 1'b0;
        EN_send_rs_put   = 1'b0;
        send_rs_put      = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

        put32(32'h00, enc_i(5, 0, 0, 1, 7'b0010011));      // ADDI x1,x0,5
        put32(32'h04, enc_s(12'h200, 1, 0, 2));            // SW x1,0x200(x0)
        put32(32'h08, enc_u(20'h10012, 2, 7'b0110111));    // LUI x2,0x10012
        put32(32'h0C, enc_u(20'h00800, 1, 7'b0110111));    // LUI x1,0x00800
        put32(32'h10, enc_s(12, 1, 2, 2));                 // SW x1,12(x2)
        put32(32'h14, enc_i(12'hAB, 0, 0, 3, 7'b0010011)); // ADDI x3,x0,0xAB
        put32(32'h18, enc_s(12'h101, 3, 0, 0));            // SB x3,0x101(x0)
        put32(32'h1C, enc_i(12'h120, 0, 0, 4, 7'b0000011)); // LB x4
        put32(32'h20, enc_i(12'h120, 0, 4, 5, 7'b0000011)); // LBU x5
        put32(32'h24, enc_s(12'h204, 4, 0, 2));
        put32(32'h28, enc_s(12'h208, 5, 0, 2));
        put32(32'h2C, enc_i(3, 0, 0, 1, 7'b0010011));      // x1 = 3
        put32(32'h30, enc_b(8, 0, 1, 1));                  // BNE x1,x0,+8
        put32(32'h34, enc_j(12, 0));                       // exit
        put32(32'h38, enc_i(-1, 1, 0, 1, 7'b0010011));     // x1 -= 1
        put32(32'h3C, enc_j(-12, 0));                      // back to BNE
        put32(32'h40, enc_u(0, 7, 7'b0010111));            // AUIPC x7,0
        put32(32'h44, enc_i(9, 7, 0, 8, 7'b1100111));      // JALR x8,9(x7)
        put32(32'h48, enc_s(12'h20C, 8, 0, 2));
        put32(32'h4C, 32'h0000_0073);                      // ECALL
        put32(32'h50, enc_i(7, 0, 0, 10, 7'b0010011));
        put32(32'h54, enc_i(-3, 0, 0, 11, 7'b0010011));
        put32(32'h58, enc_r(1, 11, 10, 0, 12));            // MUL x12,x10,x11
        put32(32'h5C, enc_s(12'h210, 12, 0, 2));
        put32(32'h60, 32'h0000_007F);
        put32(32'h101, 32'h1122_3344);
        put32(32'h120, 32'h0000_00F0);

        repeat (3) @(negedge CLK);
        chk("reset_rq_rdy", {64'h0, RDY_obtain_rq_get}, 65'h0);
        chk("reset_rs_rdy", {64'h0, RDY_send_rs_put}, 65'h0);
        chk("reset_payload", obtain_rq_get, 65'h0);
        RST = 1'b0;

        exp_rd(32'h00); serve(0, 0, 0);
        exp_rd(32'h04); serve(0, 0, 0);
        exp_wr(32'h200, 32'h5); serve(1, 0, 0);
        exp_rd(32'h08); serve(1, 0, 0);
        exp_rd(32'h0C); serve(0, 0, 0);
        exp_rd(32'h10); serve(0, 0, 0);
        exp_wr(32'h1001_200C, 32'h0080_0000); serve(1, 0, 0);
        chk("sw_no_stall", {64'h0, RDY_obtain_rq_get}, 65'h1);
        exp_rd(32'h14); serve(0, 0, 0);
        exp_rd(32'h18); serve(0, 0, 0);
        exp_rd(32'h101); serve(0, 0, 0);
        exp_wr(32'h101, 32'h1122_33AB); serve(0, 0, 0);
        exp_rd(32'h1C); serve(0, 0, 0);
        exp_rd(32'h120); serve(1, 0, 0);
        exp_rd(32'h20); serve(0, 0, 0);
        exp_rd(32'h120); serve(0, 0, 0);
        exp_rd(32'h24); serve(0, 0, 0);
        exp_wr(32'h204, 32'hFFFF_FFF0); serve(0, 0, 0);
        exp_rd(32'h28); serve(0, 0, 0);
        exp_wr(32'h208, 32'h0000_00F0); serve(1, 0, 0);
        exp_rd(32'h2C); serve(0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            exp_rd(32'h30); exp_rd(32'h38); exp_rd(32'h3C);
            serve(0, 0, 0); serve(1, 0, 0); serve(0, 0, 0);
        end
        exp_rd(32'h30); serve(0, 0, 0);
        exp_rd(32'h34); serve(0, 5, 0);
        exp_rd(32'h40); serve(0, 0, 0);
        exp_rd(32'h44); serve(0, 0, 0);
        exp_rd(32'h48); serve(1, 0, 0);
        exp_wr(32'h20C, 32'h48); serve(0, 0, 0);
        exp_rd(32'h4C); serve(0, 0, 0);
        exp_rd(32'h50); serve(0, 0, 0);
        exp_rd(32'h54); serve(0, 0, 0);
        exp_rd(32'h58); serve(0, 0, 0);
`ifdef MK_TOP_MUL_EN
        exp_rd(32'h5C); serve(0, 0, 0);
        exp_wr(32'h210, 32'hFFFF_FFEB); serve(0, 0, 0);
        exp_rd(32'h60); serve(0, 0, 0);
`endif
        check_quiet("halt_quiet");
        chk("queue_empty", 65'(exp_q.size()), 65'h0);

        // Reset while an instruction response is outstanding.
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        exp_rd(32'h00); serve(0, 0, 1);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("midrst_rq_rdy", {64'h0, RDY_obtain_rq_get}, 65'h0);
        chk("midrst_rs_rdy", {64'h0, RDY_send_rs_put}, 65'h0);
        chk("midrst_payload", obtain_rq_get, 65'h0);
        EN_send_rs_put = 1'b1;
        send_rs_put    = enc_i(1, 0, 0, 1, 7'b0010011);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("postrst_rs_rdy0", {64'h0, RDY_send_rs_put}, 65'h0);
        @(posedge CLK);
        #1;
        chk("postrst_rs_rdy1", {64'h0, RDY_send_rs_put}, 65'h0);
        EN_send_rs_put = 1'b0;
        put32(32'h00, 32'h0000_007F);
        @(negedge CLK);
        exp_rd(32'h00); serve(0, 0, 0);
        check_quiet("illegal_halt_quiet");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
